// File: rtl/turn_signal_flasher.sv
// Turn-signal flasher: conditions the left/right/hazard buttons and runs the indicator
// mode FSM with a shared 50 % duty blink timer driving the lamp commands.
module turn_signal_flasher #(
   parameter int BLINK_HALF  = 25_000_000,
   parameter int DEB_CYC     = 200_000,
   parameter int TAP_CYC     = 12_500_000,
   parameter int LANE_BLINKS = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_left,
   input  logic btn_right,
   input  logic btn_hazard,
   output logic turn_left,
   output logic turn_right,
   output logic blink_tick,
   output logic active
);

   localparam int DW   = $clog2(DEB_CYC + 1);
   localparam int TW   = $clog2(TAP_CYC + 1);
   localparam int BW   = $clog2(BLINK_HALF + 1);
   localparam int LW   = $clog2(LANE_BLINKS + 1);
   localparam int NBTN = 3;
   localparam int IDX_L = 0;
   localparam int IDX_R = 1;
   localparam int IDX_H = 2;

   typedef enum logic [1:0] {
      MODE_OFF,
      MODE_LEFT,
      MODE_RIGHT
   } mode_t;

   logic [NBTN-1:0] btn_raw;
   logic [NBTN-1:0] press_ev;
   logic [NBTN-1:0] release_ev;

   assign btn_raw = {btn_hazard, btn_right, btn_left};

   // Per button: two-flop synchroniser, then a counter that must see DEB_CYC
   // consecutive disagreeing cycles before the debounced level is allowed to follow.
   generate
      for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
         logic [1:0]    sync_q, sync_d;
         logic          deb_q, deb_d;
         logic [DW-1:0] cnt_q, cnt_d;
         logic          press_q, press_d;
         logic          rel_q, rel_d;

         always_comb begin
            sync_d  = {sync_q[0], btn_raw[gi]};
            deb_d   = deb_q;
            cnt_d   = '0;
            press_d = 1'b0;
            rel_d   = 1'b0;
            if (sync_q[1] != deb_q) begin
               if (cnt_q == DW'(DEB_CYC)) begin
                  deb_d   = sync_q[1];
                  press_d = sync_q[1];
                  rel_d   = ~sync_q[1];
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q  <= '0;
               deb_q   <= 1'b0;
               cnt_q   <= '0;
               press_q <= 1'b0;
               rel_q   <= 1'b0;
            end else begin
               sync_q  <= sync_d;
               deb_q   <= deb_d;
               cnt_q   <= cnt_d;
               press_q <= press_d;
               rel_q   <= rel_d;
            end
         end

         assign press_ev[gi]   = press_q;
         assign release_ev[gi] = rel_q;
      end
   endgenerate

   mode_t         mode_q, mode_d;
   logic          lane_q, lane_d;
   logic [LW-1:0] lane_cnt_q, lane_cnt_d;
   logic [TW-1:0] tap_q, tap_d;
   logic          hazard_q, hazard_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;
   logic          turn_left_q, turn_left_d;
   logic          turn_right_q, turn_right_d;
   logic          blink_tick_q, blink_tick_d;
   logic          active_q, active_d;

   logic go_left, go_right, tap_open, on_end;
   logic dir_evt, restart, engaged_d, idle_q;

   always_comb begin
      mode_d       = mode_q;
      lane_d       = lane_q;
      lane_cnt_d   = lane_cnt_q;
      hazard_d     = hazard_q;
      blink_cnt_d  = blink_cnt_q;
      phase_d      = phase_q;
      blink_tick_d = 1'b0;
      dir_evt      = 1'b0;
      restart      = 1'b0;

      // Simultaneous left and right presses cancel each other out.
      go_left  = press_ev[IDX_L] & ~press_ev[IDX_R];
      go_right = press_ev[IDX_R] & ~press_ev[IDX_L];
      tap_open = (tap_q < TW'(TAP_CYC));
      tap_d    = tap_open ? tap_q + 1'b1 : tap_q;
      on_end   = phase_q && (blink_cnt_q == BW'(BLINK_HALF - 1));
      idle_q   = !hazard_q && (mode_q == MODE_OFF);

      case (mode_q)
         MODE_OFF: begin
            if (go_left) begin
               mode_d  = MODE_LEFT;
               dir_evt = 1'b1;
            end else if (go_right) begin
               mode_d  = MODE_RIGHT;
               dir_evt = 1'b1;
            end
         end
         MODE_LEFT: begin
            if (go_left) begin
               mode_d  = MODE_OFF;
               dir_evt = 1'b1;
            end else if (go_right) begin
               mode_d  = MODE_RIGHT;
               dir_evt = 1'b1;
               restart = 1'b1;
            end else if (release_ev[IDX_L] && tap_open) begin
               lane_d = 1'b1;
            end
         end
         MODE_RIGHT: begin
            if (go_right) begin
               mode_d  = MODE_OFF;
               dir_evt = 1'b1;
            end else if (go_left) begin
               mode_d  = MODE_LEFT;
               dir_evt = 1'b1;
               restart = 1'b1;
            end else if (release_ev[IDX_R] && tap_open) begin
               lane_d = 1'b1;
            end
         end
         default: mode_d = MODE_OFF;
      endcase

      if (dir_evt) begin
         lane_d     = 1'b0;
         lane_cnt_d = '0;
         tap_d      = '0;
      end else if ((mode_q != MODE_OFF) && on_end) begin
         // Lane mode drops out exactly as its last ON phase ends.
         if (lane_cnt_q != LW'(LANE_BLINKS))
            lane_cnt_d = lane_cnt_q + 1'b1;
         if (lane_q && (lane_cnt_q >= LW'(LANE_BLINKS - 1))) begin
            mode_d     = MODE_OFF;
            lane_d     = 1'b0;
            lane_cnt_d = '0;
         end
      end

      if (press_ev[IDX_H])
         hazard_d = ~hazard_q;

      engaged_d = hazard_d || (mode_d != MODE_OFF);

      if (!engaged_d) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (idle_q || restart) begin
         blink_cnt_d  = '0;
         phase_d      = 1'b1;
         blink_tick_d = 1'b1;
      end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
         blink_cnt_d  = '0;
         phase_d      = ~phase_q;
         blink_tick_d = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end

      turn_left_d  = phase_d && (hazard_d || (mode_d == MODE_LEFT));
      turn_right_d = phase_d && (hazard_d || (mode_d == MODE_RIGHT));
      active_d     = engaged_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q       <= MODE_OFF;
         lane_q       <= 1'b0;
         lane_cnt_q   <= '0;
         tap_q        <= '0;
         hazard_q     <= 1'b0;
         blink_cnt_q  <= '0;
         phase_q      <= 1'b0;
         turn_left_q  <= 1'b0;
         turn_right_q <= 1'b0;
         blink_tick_q <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         lane_q       <= lane_d;
         lane_cnt_q   <= lane_cnt_d;
         tap_q        <= tap_d;
         hazard_q     <= hazard_d;
         blink_cnt_q  <= blink_cnt_d;
         phase_q      <= phase_d;
         turn_left_q  <= turn_left_d;
         turn_right_q <= turn_right_d;
         blink_tick_q <= blink_tick_d;
         active_q     <= active_d;
      end
   end

   assign turn_left  = turn_left_q;
   assign turn_right = turn_right_q;
   assign blink_tick = blink_tick_q;
   assign active     = active_q;

endmodule

// File: tb/tb_turn_signal_flasher.sv
// Scoreboard bench for turn_signal_flasher: stimulus pushes cycle-stamped expected
// outputs, an independent monitor pops and compares them on the falling edge.
module tb_turn_signal_flasher;

    localparam int HALF = 4;
    localparam int DEB  = 3;
    localparam int TAP  = 10;
    localparam int LANE = 3;
    localparam int PER  = 2 * HALF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic btn_hazard = 1'b0;
    logic turn_left, turn_right, blink_tick, active;

    turn_signal_flasher #(
        .BLINK_HALF (HALF),
        .DEB_CYC    (DEB),
        .TAP_CYC    (TAP),
        .LANE_BLINKS(LANE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_hazard(btn_hazard),
        .turn_left (turn_left),
        .turn_right(turn_right),
        .blink_tick(blink_tick),
        .active    (active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [3:0] v;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_t   = 0;

    // Expected vector order: {turn_left, turn_right, blink_tick, active}
    task automatic push(input int t, input logic tl, input logic tr, input logic bt,
                        input logic act, input string nm);
        exp_t e;
        e.t = t;
        e.v = {tl, tr, bt, act};
        e.name = nm;
        q.push_back(e);
        last_t = t;
    endtask

    task automatic push_idle(input int from, input int to, input string nm);
        for (int t = from; t <= to; t++) push(t, 1'b0, 1'b0, 1'b0, 1'b0, nm);
    endtask

    // Steady blinking that started (ON, tick) at cycle e0 without any restart since.
    task automatic push_blink(input int e0, input int from, input int to,
                              input logic l, input logic r, input string nm);
        for (int t = from; t <= to; t++) begin
            int   rel;
            logic ph;
            rel = (t - e0) % PER;
            ph  = (rel < HALF);
            push(t, ph & l, ph & r, rel == 0, 1'b1, nm);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic step(input int t, input logic rs, input logic l, input logic r, input logic h);
        wait_cyc(t);
        rst = rs;
        btn_left = l;
        btn_right = r;
        btn_hazard = h;
        $display("cyc %0d: drive rst=%b left=%b right=%b hazard=%b", cyc, rs, l, r, h);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].t <= cyc) begin
            e = q.pop_front();
            n_checks++;
            if (e.t < cyc || {turn_left, turn_right, blink_tick, active} !== e.v) begin
                n_fail++;
                $display("FAIL %s cyc=%0d (due %0d): got L/R/tick/act=%b, expected %b",
                         e.name, cyc, e.t, {turn_left, turn_right, blink_tick, active}, e.v);
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 1) begin
            n_checks++;
            if ((blink_tick || turn_left || turn_right) && (active !== 1'b1)) begin
                n_fail++;
                $display("FAIL invariant cyc=%0d: L/R/tick high while active=%b",
                         cyc, active);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, e0, c2, c3, c4;

        wait_cyc(1);
        push_idle(2, 3, "reset");
        step(3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bouncing left button: never stable for long enough, nothing happens.
        wait_cyc(last_t + 1);
        c = cyc;
        push_idle(c + 1, c + 24, "bounce");
        for (int k = 0; k <= 6; k++)
            step(c + 2 * k, 1'b0, (k % 2 == 0) && (k < 6), 1'b0, 1'b0);

        // Latched left, then cancelled mid-ON by a second left press.
        wait_cyc(last_t + 1);
        c = cyc;
        e0 = c + 7;
        push(c + 6, 1'b0, 1'b0, 1'b0, 1'b0, "latch_pre");
        push_blink(e0, e0, c + 39, 1'b1, 1'b0, "latch_left");
        push_idle(c + 40, c + 53, "cancel_left");
        step(c, 1'b0, 1'b1, 1'b0, 1'b0);
        step(c + 20, 1'b0, 1'b0, 1'b0, 1'b0);
        step(c + 33, 1'b0, 1'b1, 1'b0, 1'b0);
        step(c + 39, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lane-change tap on right: three ON phases then auto-cancel.
        wait_cyc(last_t + 1);
        c = cyc;
        e0 = c + 7;
        push_idle(c + 1, c + 6, "lane_pre");
        push_blink(e0, e0, e0 + 19, 1'b0, 1'b1, "lane_right");
        push_idle(e0 + 20, e0 + 35, "lane_done");
        step(c, 1'b0, 1'b0, 1'b1, 1'b0);
        step(c + 5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hazard on and off over a latched left, no timer restart.
        wait_cyc(last_t + 1);
        c = cyc;
        e0 = c + 7;
        push_idle(c + 1, c + 6, "haz_pre");
        push_blink(e0, e0, c + 16, 1'b1, 1'b0, "haz_left_only");
        push_blink(e0, c + 17, c + 32, 1'b1, 1'b1, "haz_both");
        push_blink(e0, c + 33, c + 51, 1'b1, 1'b0, "haz_off_left");
        push_idle(c + 52, c + 60, "haz_cancel");
        step(c, 1'b0, 1'b1, 1'b0, 1'b0);
        step(c + 10, 1'b0, 1'b1, 1'b0, 1'b1);
        step(c + 12, 1'b0, 1'b0, 1'b0, 1'b1);
        step(c + 16, 1'b0, 1'b0, 1'b0, 1'b0);
        step(c + 26, 1'b0, 1'b0, 1'b0, 1'b1);
        step(c + 32, 1'b0, 1'b0, 1'b0, 1'b0);
        step(c + 45, 1'b0, 1'b1, 1'b0, 1'b0);
        step(c + 51, 1'b0, 1'b0, 1'b0, 1'b0);

        // Left and right pressed together from OFF: ignored.
        wait_cyc(last_t + 1);
        c = cyc;
        push_idle(c + 1, c + 25, "simul_lr");
        step(c, 1'b0, 1'b1, 1'b1, 1'b0);
        step(c + 12, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hazard and left pressed together: both blink, then hazard off leaves left.
        wait_cyc(last_t + 1);
        c = cyc;
        e0 = c + 7;
        push_idle(c + 1, c + 6, "simul_hl_pre");
        push_blink(e0, e0, c + 26, 1'b1, 1'b1, "simul_hl_both");
        push_blink(e0, c + 27, c + 46, 1'b1, 1'b0, "simul_hl_left");
        push_idle(c + 47, c + 55, "simul_hl_cancel");
        step(c, 1'b0, 1'b1, 1'b0, 1'b1);
        step(c + 6, 1'b0, 1'b1, 1'b0, 1'b0);
        step(c + 12, 1'b0, 1'b0, 1'b0, 1'b0);
        step(c + 20, 1'b0, 1'b0, 1'b0, 1'b1);
        step(c + 26, 1'b0, 1'b0, 1'b0, 1'b0);
        step(c + 40, 1'b0, 1'b1, 1'b0, 1'b0);
        step(c + 46, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-ON, full-latency re-press, then LEFT -> RIGHT restart and cancel.
        wait_cyc(last_t + 1);
        c  = cyc;
        e0 = c + 7;
        c2 = c + 15;
        c3 = c2 + 21;
        c4 = c3 + 25;
        push_idle(c + 1, c + 6, "rst_pre");
        push_blink(e0, e0, c + 9, 1'b1, 1'b0, "rst_blink");
        push_idle(c + 10, c2 + 6, "rst_zero");
        push_blink(c2 + 7, c2 + 7, c3 + 6, 1'b1, 1'b0, "repress_left");
        push_blink(c3 + 7, c3 + 7, c4 + 6, 1'b0, 1'b1, "switch_right");
        push_idle(c4 + 7, c4 + 15, "cancel_right");
        step(c, 1'b0, 1'b1, 1'b0, 1'b0);
        step(c + 9, 1'b1, 1'b0, 1'b0, 1'b0);
        step(c + 10, 1'b0, 1'b0, 1'b0, 1'b0);
        step(c2, 1'b0, 1'b1, 1'b0, 1'b0);
        step(c2 + 12, 1'b0, 1'b0, 1'b0, 1'b0);
        step(c3, 1'b0, 1'b0, 1'b1, 1'b0);
        step(c3 + 12, 1'b0, 1'b0, 1'b0, 1'b0);
        step(c4, 1'b0, 1'b0, 1'b1, 1'b0);
        step(c4 + 6, 1'b0, 1'b0, 1'b0, 1'b0);

        wait_cyc(last_t + 2);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.t);
        end

        if (n_checks < 1) begin
            n_fail++;
            $display("FAIL summary: no expectations were evaluated");
        end

        if (n_fail == 0)
            $display("PASS: all %0d checks passed", n_checks);
        else
            $display("FAIL: %0d of %0d checks failed", n_fail, n_checks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/turn_signal_flasher.md
# turn_signal_flasher

Generates the blinking `turn_left` / `turn_right` lamp commands that the lamp controller drives onto LED7/6 and LED1/0. It conditions three raw push-button inputs: two-flop sync, then debounce. It runs the indicator state machine: latched turn, 3-blink lane-change tap, and hazard override. A shared blink-phase timer produces a 50 % duty flash. It also emits a click pulse for the buzzer block.

## Interface
- `BLINK_HALF`, 25_000_000: cycles per half flash period (ON time = OFF time).
- `DEB_CYC`, 200_000: consecutive stable synced cycles required to accept a level change.
- `TAP_CYC`, 12_500_000: a release within this many cycles of the press event makes it a lane-change tap.
- `LANE_BLINKS`, 3: ON phases shown in lane-change mode before auto-cancel.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_left` in 1: raw left-indicator button, active-high, asynchronous.
- `btn_right` in 1: raw right-indicator button, active-high, asynchronous.
- `btn_hazard` in 1: raw hazard button, active-high, asynchronous.
- `turn_left` out 1: left lamp command, registered.
- `turn_right` out 1: right lamp command, registered.
- `blink_tick` out 1: one-cycle pulse at the start of every ON phase.
- `active` out 1: high when any indicator or the hazard is engaged, registered.

## Operation
- **Input conditioning, per button:** two-flop synchroniser, then debounce counter.
  - The debounced level takes the synced value once it has differed for `DEB_CYC` consecutive cycles.
  - Any agreement between the synced value and the debounced level clears the counter.
  - A press event is a one-cycle pulse on the rising debounced edge; a release event is the same on the falling edge.
- **Mode FSM:** states OFF, LEFT, RIGHT, plus a `lane` flag and a separate `hazard` flag.
  - OFF + left press → LEFT, with `lane` = 0. The tap timer starts.
  - Left release while the tap timer is < `TAP_CYC` → `lane` = 1. After `TAP_CYC` the tap timer stops and releases are ignored.
  - LEFT + left press → OFF. The release of that press is ignored.
  - LEFT + right press → RIGHT. This is a fresh entry: the tap timer restarts and `lane` = 0.
  - RIGHT mirrors LEFT.
  - Left and right press in the same cycle → both ignored.
- **Lane mode:** a counter counts completed ON phases. At the end of the `LANE_BLINKS`-th ON phase → OFF.
  - A new direction press clears the counter.
- **Hazard:** each hazard press toggles `hazard`.
  - It is independent of the mode FSM. Mode and lane counting continue underneath it.
  - A hazard press and a direction press in the same cycle are both processed.
- **Blink timer:**
  - Counter 0..`BLINK_HALF`-1; `phase` toggles on wrap.
  - Going from idle (OFF and !hazard) to engaged forces counter = 0 and `phase` = ON.
  - A direction change LEFT↔RIGHT also restarts the timer at ON.
  - Toggling hazard while already engaged does not restart it.
  - When idle, the counter is held at 0 and `phase` = OFF.
- **Outputs:**
  - `turn_left` = `phase` & (hazard | LEFT).
  - `turn_right` = `phase` & (hazard | RIGHT).
  - `active` = hazard | (mode != OFF).
  - `blink_tick` pulses when `phase` becomes ON, including a forced restart.

## Timing
- All outputs are registered. Reset values: `turn_left` = 0, `turn_right` = 0, `blink_tick` = 0, `active` = 0. State after reset is OFF, `hazard` = 0, `lane` = 0, all counters 0.
- Debounced levels reset to 0. A button held through reset therefore produces a press event `DEB_CYC`+2 cycles after reset deasserts.
- Press latency: raw rise sampled at edge N, held stable → press event at edge N+`DEB_CYC`+2 → `turn_*`, `active` and `blink_tick` high at edge N+`DEB_CYC`+3.
- ON phase and OFF phase each last exactly `BLINK_HALF` cycles. The first ON phase after engage is full length.
- Lane cancel: on the cycle the last ON phase ends, `turn_*` goes 0 and `active` goes 0 together. No trailing OFF phase is counted.
- Cancel by pressing the same direction again: outputs go 0 one cycle after the press event, even mid-ON-phase.
- Reset asserted mid-blink: all outputs are 0 on the next edge.

## Test plan
Parameters for the bench: `BLINK_HALF`=4, `DEB_CYC`=3, `TAP_CYC`=10, `LANE_BLINKS`=3.

1. **Latched left:** hold `btn_left` 20 cycles, then release. `turn_left` = 1 from cycle 6 after the rise. It then repeats 4 high / 4 low indefinitely. `blink_tick` pulses every 8 cycles; `turn_right` stays 0; `active` stays 1.
2. **Lane tap:** `btn_right` high for 5 cycles → exactly 3 ON phases on `turn_right`, then `turn_right` = 0 and `active` = 0, with no further `blink_tick`.
3. **Bounce rejection and cancel:** `btn_left` toggling every 2 cycles for 12 cycles → no press event, outputs stay 0. Then a clean latched left followed by a second left press → `turn_left` = 0 one cycle after the second press event, and `active` = 0.
4. **Hazard over left:** hazard press while LEFT is latched → both lamps blink in phase with no timer restart. A second hazard press → only `turn_left` continues blinking.
5. **Simultaneous presses:** left and right press events in the same cycle from OFF → state stays OFF and outputs stay 0. Hazard and left press in the same cycle → both lamps blink; after a hazard toggle-off, `turn_left` alone remains.
6. **Reset mid-blink and direction switch:**
   - Assert `rst` during an ON phase → all outputs 0 next cycle; a re-press then requires the full debounce again.
   - LEFT → right press → `turn_right` = 1 and `blink_tick` = 1 one cycle after the event.
